// File: rtl/or1200_refill_pkg.sv
// Shared types and constants for the IC/DC refill arbiter: FSM states,
// owner encoding, default burst length and the line-offset field bounds.
package or1200_refill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IC_XFER = 2'd1,
        ST_DC_XFER = 2'd2
    } state_e;

    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    localparam int BURST_BEATS_DEF = 4;

    // Word offset inside a 16-byte line; the only address bits a burst walks.
    localparam int OFS_HI = 3;
    localparam int OFS_LO = 2;

endpackage

// File: rtl/or1200_refill_pick.sv
// Combinational two-way picker between the IC and DC refill requests.
// OR1200_REFILL_ARB_RR_EN selects round-robin; otherwise DC has fixed priority.
module or1200_refill_pick
    import or1200_refill_pkg::*;
(
    input  logic ic_req,
    input  logic dc_req,
    input  logic last,
    output logic pick_ic,
    output logic pick_dc
);

`ifdef OR1200_REFILL_ARB_RR_EN
    always_comb begin
        pick_ic = 1'b0;
        pick_dc = 1'b0;
        if (ic_req && dc_req) begin
            // Both asking: the side that did not finish most recently wins.
            if (last == OWN_DC) pick_ic = 1'b1;
            else                pick_dc = 1'b1;
        end else begin
            pick_ic = ic_req;
            pick_dc = dc_req;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        pick_ic = 1'b0;
        pick_dc = 1'b0;
        pick_dc = dc_req;
        pick_ic = ic_req & ~dc_req;
    end
`endif

endmodule

// File: rtl/or1200_refill_arb.sv
// Shares one BIU port between the IC and DC refill FSMs, holding the grant for a
// single beat or a critical-word-first line burst. Arbitration mode: OR1200_REFILL_ARB_RR_EN.
module or1200_refill_arb
    import or1200_refill_pkg::*;
#(
    parameter int BURST_BEATS = BURST_BEATS_DEF,
    parameter int AW          = 32,
    parameter int DW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ic_req,
    input  logic          ic_burst,
    input  logic [AW-1:0] ic_addr,
    output logic          ic_ack,
    output logic          ic_err,
    output logic [DW-1:0] ic_dat,
    input  logic          dc_req,
    input  logic          dc_burst,
    input  logic [AW-1:0] dc_addr,
    input  logic          dc_we,
    input  logic [DW-1:0] dc_wdat,
    output logic          dc_ack,
    output logic          dc_err,
    output logic [DW-1:0] dc_dat,
    output logic          biu_cyc,
    output logic          biu_stb,
    output logic          biu_cab,
    output logic          biu_we,
    output logic [AW-1:0] biu_adr,
    output logic [DW-1:0] biu_wdat,
    input  logic          biu_ack,
    input  logic          biu_err,
    input  logic [DW-1:0] biu_dat,
    output logic          gnt_ic,
    output logic          gnt_dc
);

    localparam logic [1:0] CNT_BURST = 2'(BURST_BEATS - 1);

    state_e        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [AW-1:0] adr_q, adr_d;
    logic          burst_q, burst_d;
    logic          we_q, we_d;
    logic          last_q, last_d;

    logic pick_ic, pick_dc;
    logic owner_req;
    logic owner;
    logic dc_line;

    or1200_refill_pick u_pick (
        .ic_req  (ic_req),
        .dc_req  (dc_req),
        .last    (last_q),
        .pick_ic (pick_ic),
        .pick_dc (pick_dc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            adr_q   <= '0;
            burst_q <= 1'b0;
            we_q    <= 1'b0;
            last_q  <= OWN_DC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            burst_q <= burst_d;
            we_q    <= we_d;
            last_q  <= last_d;
        end
    end

    // A DC burst write is illegal and is demoted to a single-beat write.
    assign dc_line   = dc_burst & ~dc_we;
    assign owner     = (state_q == ST_DC_XFER) ? OWN_DC : OWN_IC;
    assign owner_req = (state_q == ST_DC_XFER) ? dc_req : ic_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        burst_d = burst_q;
        we_d    = we_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_dc) begin
                    state_d = ST_DC_XFER;
                    adr_d   = dc_addr;
                    burst_d = dc_line;
                    we_d    = dc_we;
                    cnt_d   = dc_line ? CNT_BURST : 2'd0;
                end else if (pick_ic) begin
                    state_d = ST_IC_XFER;
                    adr_d   = ic_addr;
                    burst_d = ic_burst;
                    we_d    = 1'b0;
                    cnt_d   = ic_burst ? CNT_BURST : 2'd0;
                end
            end
            ST_IC_XFER, ST_DC_XFER: begin
                if (biu_err || !owner_req) begin
                    state_d = ST_IDLE;
                end else if (biu_ack) begin
                    if (cnt_q != 2'd0) begin
                        cnt_d                = cnt_q - 2'd1;
                        adr_d[OFS_HI:OFS_LO] = adr_q[OFS_HI:OFS_LO] + 2'd1;
                    end else begin
                        state_d = ST_IDLE;
                        last_d  = owner;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_ic   = (state_q == ST_IC_XFER);
        gnt_dc   = (state_q == ST_DC_XFER);
        biu_cyc  = gnt_ic | gnt_dc;
        biu_stb  = gnt_ic | gnt_dc;
        biu_cab  = (gnt_ic | gnt_dc) & burst_q;
        biu_we   = gnt_dc & we_q;
        biu_adr  = (gnt_ic | gnt_dc) ? adr_q : '0;
        biu_wdat = gnt_dc ? dc_wdat : '0;
        ic_ack   = gnt_ic & biu_ack & ~biu_err;
        ic_err   = gnt_ic & biu_err;
        ic_dat   = gnt_ic ? biu_dat : '0;
        dc_ack   = gnt_dc & biu_ack & ~biu_err;
        dc_err   = gnt_dc & biu_err;
        dc_dat   = gnt_dc ? biu_dat : '0;
    end

endmodule

// File: tb/tb_or1200_refill_arb.sv
// Directed bench for or1200_refill_arb: burst wrap, contention order, error,
// ack+err collision, requester abort and asynchronous reset mid-burst.
module tb_or1200_refill_arb;

    logic        clk;
    logic        rst;
    logic        ic_req, ic_burst;
    logic [31:0] ic_addr;
    logic        ic_ack, ic_err;
    logic [31:0] ic_dat;
    logic        dc_req, dc_burst, dc_we;
    logic [31:0] dc_addr, dc_wdat;
    logic        dc_ack, dc_err;
    logic [31:0] dc_dat;
    logic        biu_cyc, biu_stb, biu_cab, biu_we;
    logic [31:0] biu_adr, biu_wdat;
    logic        biu_ack, biu_err;
    logic [31:0] biu_dat;
    logic        gnt_ic, gnt_dc;

    int n_tests = 0;
    int n_fail  = 0;
    int ack_cnt;
    int err_cnt;

    or1200_refill_arb dut (
        .clk      (clk),
        .rst      (rst),
        .ic_req   (ic_req),
        .ic_burst (ic_burst),
        .ic_addr  (ic_addr),
        .ic_ack   (ic_ack),
        .ic_err   (ic_err),
        .ic_dat   (ic_dat),
        .dc_req   (dc_req),
        .dc_burst (dc_burst),
        .dc_addr  (dc_addr),
        .dc_we    (dc_we),
        .dc_wdat  (dc_wdat),
        .dc_ack   (dc_ack),
        .dc_err   (dc_err),
        .dc_dat   (dc_dat),
        .biu_cyc  (biu_cyc),
        .biu_stb  (biu_stb),
        .biu_cab  (biu_cab),
        .biu_we   (biu_we),
        .biu_adr  (biu_adr),
        .biu_wdat (biu_wdat),
        .biu_ack  (biu_ack),
        .biu_err  (biu_err),
        .biu_dat  (biu_dat),
        .gnt_ic   (gnt_ic),
        .gnt_dc   (gnt_dc)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // inputs change on the falling edge; checks follow #1 later
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ic_req = 0; ic_burst = 0; ic_addr = '0;
        dc_req = 0; dc_burst = 0; dc_addr = '0; dc_we = 0; dc_wdat = '0;
        biu_ack = 0; biu_err = 0; biu_dat = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cyc"}, {31'd0, biu_cyc}, 0);
        check({tag, "_stb"}, {31'd0, biu_stb}, 0);
        check({tag, "_cab"}, {31'd0, biu_cab}, 0);
        check({tag, "_adr"}, biu_adr, 0);
        check({tag, "_gnt"}, {30'd0, gnt_ic, gnt_dc}, 0);
        check({tag, "_acks"}, {28'd0, ic_ack, ic_err, dc_ack, dc_err}, 0);
    endtask

    logic [31:0] exp_adr [4];
    logic        exp_dc_first [3];

    initial begin
        clear_inputs();
        rst = 0;
        #2;
        check_all_zero("reset");
        step(); step();
        rst = 1;

        // IC burst alone, critical-word-first wrap
        exp_adr[0] = 32'h1008; exp_adr[1] = 32'h100C;
        exp_adr[2] = 32'h1000; exp_adr[3] = 32'h1004;
        step();
        ic_req = 1; ic_burst = 1; ic_addr = 32'h0000_1008; biu_ack = 1;
        #1 check("ic_idle_cyc", {31'd0, biu_cyc}, 0);
        ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            biu_dat = 32'hA000_0000 + 32'(i);
            #1;
            check("ic_burst_adr", biu_adr, exp_adr[i]);
            check("ic_burst_dat", ic_dat, 32'hA000_0000 + 32'(i));
            check("ic_burst_cab", {31'd0, biu_cab}, 1);
            check("ic_burst_dc_dat", dc_dat, 0);
            if (ic_ack) ack_cnt++;
        end
        step();
        ic_req = 0; biu_ack = 0;
        #1;
        check("ic_burst_ackcnt", ack_cnt, 4);
        check("ic_burst_done_cyc", {31'd0, biu_cyc}, 0);

        // contention from reset
`ifdef OR1200_REFILL_ARB_RR_EN
        exp_dc_first[0] = 0; exp_dc_first[1] = 1; exp_dc_first[2] = 0;
`else
        exp_dc_first[0] = 1; exp_dc_first[1] = 1; exp_dc_first[2] = 1;
`endif
        step(); rst = 0;
        step(); rst = 1;
        ic_req = 1; dc_req = 1; ic_burst = 0; dc_burst = 0; dc_we = 0;
        ic_addr = 32'h0000_7000; dc_addr = 32'h0000_8000; biu_ack = 1;
        #1 check("cont_idle_cyc", {31'd0, biu_cyc}, 0);
        for (int g = 0; g < 3; g++) begin
            step();
            #1;
            check("cont_gnt_dc", {31'd0, gnt_dc}, {31'd0, exp_dc_first[g]});
            check("cont_gnt_ic", {31'd0, gnt_ic}, {31'd0, ~exp_dc_first[g]});
            check("cont_adr", biu_adr, exp_dc_first[g] ? 32'h8000 : 32'h7000);
            step();
            if (g == 2) begin
                ic_req = 0; dc_req = 0;
            end
            #1 check("cont_dead_cyc", {31'd0, biu_cyc}, 0);
        end

        // DC burst with error on beat 2
        step();
        biu_ack = 0; dc_req = 1; dc_burst = 1; dc_addr = 32'h0000_2004;
        ack_cnt = 0; err_cnt = 0;
        step();
        ic_req = 1; biu_ack = 1; biu_dat = 32'h1111_2222;
        #1;
        check("err_b1_adr", biu_adr, 32'h2004);
        check("err_b1_dc_dat", dc_dat, 32'h1111_2222);
        check("err_b1_ic_ack", {31'd0, ic_ack}, 0);
        check("err_b1_ic_dat", ic_dat, 0);
        if (dc_ack) ack_cnt++;
        step();
        biu_ack = 0; biu_err = 1;
        #1;
        check("err_b2_adr", biu_adr, 32'h2008);
        check("err_b2_ic_err", {31'd0, ic_err}, 0);
        if (dc_ack) ack_cnt++;
        if (dc_err) err_cnt++;
        step();
        biu_err = 0; dc_req = 0; ic_req = 0;
        #1;
        check("err_idle_cyc", {31'd0, biu_cyc}, 0);
        if (dc_err) err_cnt++;
        check("err_ack_cnt", ack_cnt, 1);
        check("err_err_cnt", err_cnt, 1);

        // ack and err together on the last beat
        step();
        dc_req = 1; dc_burst = 0; dc_addr = 32'h0000_5000;
        step();
        biu_ack = 1; biu_err = 1;
        #1;
        check("ackerr_err", {31'd0, dc_err}, 1);
        check("ackerr_ack", {31'd0, dc_ack}, 0);
        step();
        dc_req = 0; biu_ack = 0; biu_err = 0;
        #1 check("ackerr_idle_cyc", {31'd0, biu_cyc}, 0);

        // IC aborts after beat 1; pending DC (illegal burst write) follows
        step();
        ic_req = 1; ic_burst = 1; ic_addr = 32'h0000_3000;
        step();
        biu_ack = 1;
        #1;
        check("abort_b1_adr", biu_adr, 32'h3000);
        check("abort_b1_ack", {31'd0, ic_ack}, 1);
        step();
        ic_req = 0; biu_ack = 0;
        dc_req = 1; dc_we = 1; dc_burst = 1; dc_addr = 32'h0000_6000; dc_wdat = 32'hDEAD_BEEF;
        #1;
        check("abort_still_cyc", {31'd0, biu_cyc}, 1);
        check("abort_wdat_gated", biu_wdat, 0);
        step();
        #1;
        check("abort_idle_cyc", {31'd0, biu_cyc}, 0);
        check("abort_no_err", {31'd0, ic_err}, 0);
        check("abort_no_gnt_dc", {31'd0, gnt_dc}, 0);
        step();
        biu_ack = 1;
        #1;
        check("wr_gnt_dc", {31'd0, gnt_dc}, 1);
        check("wr_cab", {31'd0, biu_cab}, 0);
        check("wr_we", {31'd0, biu_we}, 1);
        check("wr_wdat", biu_wdat, 32'hDEAD_BEEF);
        check("wr_adr", biu_adr, 32'h6000);
        check("wr_ack", {31'd0, dc_ack}, 1);
        step();
        dc_req = 0; dc_we = 0; dc_burst = 0; biu_ack = 0;
        #1 check("wr_done_cyc", {31'd0, biu_cyc}, 0);

        // asynchronous reset between beats 2 and 3
        step();
        ic_req = 1; ic_burst = 1; ic_addr = 32'h0000_4008;
        step();
        biu_ack = 1;
        #1 check("rst_b1_adr", biu_adr, 32'h4008);
        step();
        #1 check("rst_b2_adr", biu_adr, 32'h400C);
        step();
        rst = 0;
        #1;
        check_all_zero("rst_mid");
        #2 rst = 1;
        step();
        biu_ack = 0;
        #1;
        check("rst_regrant_gnt", {31'd0, gnt_ic}, 1);
        check("rst_regrant_adr", biu_adr, 32'h4008);
        check("rst_regrant_cab", {31'd0, biu_cab}, 1);
        step();
        ic_req = 0;
        step();
        #1 check("rst_final_cyc", {31'd0, biu_cyc}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
